// File: rtl/hidden_cpu_sequencer_pkg.sv
// Shared definitions for the HiddenCPU program sequencer: state encoding and
// instruction field widths.
package hidden_cpu_sequencer_pkg;
  localparam int OPC_W   = 2;
  localparam int REG_W   = 2;
  localparam int INSTR_W = OPC_W + 2 * REG_W;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BOOT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4
  } seq_state_e;
endpackage

// File: rtl/hidden_cpu_sequencer_prog_mem.sv
// Program store: DEPTH x INSTR_W register file, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module hcpu_prog_mem
  import hidden_cpu_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/hidden_cpu_sequencer.sv
// Program store and run controller for the HiddenCPU core: load, run, pause,
// single-step and breakpoint, driving the core's instruction field and reset.
module hidden_cpu_sequencer
  import hidden_cpu_sequencer_pkg::*;
#(
  parameter int                 DEPTH     = 16,
  parameter int                 ADDR_W    = $clog2(DEPTH),
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  input  logic               run,
  input  logic               halt,
  input  logic               step,
  input  logic               restart,
  input  logic               bp_en,
  input  logic [7:0]         bp_addr,
  input  logic [7:0]         core_pc,
  output logic [INSTR_W-1:0] core_instr,
  output logic               core_rst,
  output logic [2:0]         state,
  output logic               done,
  output logic               bp_hit,
  output logic [15:0]        exec_count
);
  localparam int PLEN_W = ADDR_W + 1;

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PLEN_W-1:0]  prog_len_q, prog_len_d;
  logic [15:0]        exec_count_q, exec_count_d;
  logic [INSTR_W-1:0] core_instr_q, core_instr_d;
  logic               done_q, done_d, bp_hit_q, bp_hit_d, bypass_q, bypass_d;
  logic               core_rst_q, core_rst_d, load_ready_q, load_ready_d;
  logic [INSTR_W-1:0] rd_data;
  logic               mem_we, issue, past_end, bp_match;

  hcpu_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (load_data),
    .raddr (core_pc[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  // prog_len may equal 256, so compare at 9 bits.
  assign past_end = {1'b0, core_pc} >= 9'(prog_len_q);
  assign bp_match = bp_en && (core_pc == bp_addr);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    exec_count_d = exec_count_q;
    done_d       = done_q;
    bp_hit_d     = bp_hit_q;
    bypass_d     = bypass_q;
    core_instr_d = NOP_INSTR;
    mem_we       = 1'b0;
    issue        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end else if (run && prog_len_q != '0) begin
          state_d = ST_BOOT;
        end
      end
      ST_LOAD: begin
        if (halt) begin
          state_d = ST_IDLE;
        end else if (load_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (load_last || wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            prog_len_d = PLEN_W'(wr_ptr_q) + PLEN_W'(1);
            state_d    = ST_IDLE;
          end
        end
      end
      ST_BOOT: begin
        done_d       = 1'b0;
        bp_hit_d     = 1'b0;
        bypass_d     = 1'b0;
        exec_count_d = '0;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        bypass_d = 1'b0;
        if (halt) begin
          state_d = ST_PAUSE;
        end else if (past_end) begin
          state_d = ST_PAUSE;
          done_d  = 1'b1;
        end else if (bp_match && !bypass_q) begin
          state_d  = ST_PAUSE;
          bp_hit_d = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (halt) begin
          state_d = ST_PAUSE;
        end else if (restart) begin
          state_d = ST_BOOT;
        end else if (step) begin
          issue = !done_q;
        end else if (run) begin
          // Resuming on the breakpoint pc must not re-trigger it immediately.
          state_d  = ST_RUN;
          bypass_d = (core_pc == bp_addr);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      core_instr_d = rd_data;
      if (exec_count_q != 16'hFFFF) exec_count_d = exec_count_q + 16'd1;
    end
    core_rst_d   = !(state_d == ST_RUN || state_d == ST_PAUSE);
    load_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      exec_count_q <= '0;
      done_q       <= 1'b0;
      bp_hit_q     <= 1'b0;
      bypass_q     <= 1'b0;
      core_instr_q <= NOP_INSTR;
      core_rst_q   <= 1'b1;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      exec_count_q <= exec_count_d;
      done_q       <= done_d;
      bp_hit_q     <= bp_hit_d;
      bypass_q     <= bypass_d;
      core_instr_q <= core_instr_d;
      core_rst_q   <= core_rst_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign state      = state_q;
  assign core_instr = core_instr_q;
  assign core_rst   = core_rst_q;
  assign load_ready = load_ready_q;
  assign done       = done_q;
  assign bp_hit     = bp_hit_q;
  assign exec_count = exec_count_q;
endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// Scoreboard bench for hidden_cpu_sequencer: a behavioural model of the
// sequencer plus a toy core program counter drive stimulus and expectations.
module tb_hidden_cpu_sequencer;
  localparam int DEPTH = 16;
  localparam int S_IDLE = 0, S_LOAD = 1, S_BOOT = 2, S_RUN = 3, S_PAUSE = 4;

  logic       clk = 1'b0;
  logic       rst, load_start, load_valid, load_ready, load_last;
  logic       run, halt, step, restart, bp_en, core_rst, done, bp_hit;
  logic [5:0] load_data, core_instr;
  logic [7:0] bp_addr, core_pc;
  logic [2:0] state;
  logic [15:0] exec_count;

  always #5 clk = ~clk;

  hidden_cpu_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .run(run), .halt(halt), .step(step), .restart(restart), .bp_en(bp_en),
    .bp_addr(bp_addr), .core_pc(core_pc), .core_instr(core_instr),
    .core_rst(core_rst), .state(state), .done(done), .bp_hit(bp_hit),
    .exec_count(exec_count)
  );

  typedef struct packed {
    logic rst, load_start, load_valid, load_last, run, halt, step, restart;
    logic [5:0] load_data;
  } in_t;

  typedef struct packed {
    logic [5:0]  instr;
    logic        crst;
    logic [2:0]  st;
    logic        done;
    logic        bp;
    logic [15:0] cnt;
    logic        lr;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0, n_fail = 0;

  // Reference model state
  int         m_st = S_IDLE, m_len = 0, m_wp = 0, m_cnt = 0, m_pc = 0;
  bit         m_done = 0, m_bp = 0, m_byp = 0, jumps = 0;
  logic [5:0] m_mem [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the expectation.
  task automatic cyc(input in_t d);
    bit   iss = 0, byp_now;
    int   nst;
    exp_t e;
    rst = d.rst; load_start = d.load_start; load_valid = d.load_valid;
    load_last = d.load_last; load_data = d.load_data; run = d.run;
    halt = d.halt; step = d.step; restart = d.restart; core_pc = 8'(m_pc);
    e.instr = 6'd0;
    if (d.rst) begin
      m_st = S_IDLE; m_len = 0; m_wp = 0; m_cnt = 0; m_pc = 0;
      m_done = 0; m_bp = 0; m_byp = 0;
    end else begin
      nst = m_st;
      case (m_st)
        S_IDLE: if (d.load_start) begin nst = S_LOAD; m_wp = 0; end
                else if (d.run && m_len != 0) nst = S_BOOT;
        S_LOAD: if (d.halt) nst = S_IDLE;
                else if (d.load_valid) begin
                  m_mem[m_wp] = d.load_data;
                  if (d.load_last || m_wp == DEPTH - 1) begin m_len = m_wp + 1; nst = S_IDLE; end
                  m_wp = (m_wp + 1) % DEPTH;
                end
        S_BOOT: begin m_done = 0; m_bp = 0; m_cnt = 0; m_byp = 0; nst = S_RUN; end
        S_RUN: begin
          byp_now = m_byp; m_byp = 0;
          if (d.halt) nst = S_PAUSE;
          else if (m_pc >= m_len) begin nst = S_PAUSE; m_done = 1; end
          else if (bp_en && m_pc == int'(bp_addr) && !byp_now) begin nst = S_PAUSE; m_bp = 1; end
          else iss = 1;
        end
        default: begin
          if (d.halt) nst = S_PAUSE;
          else if (d.restart) nst = S_BOOT;
          else if (d.step) iss = !m_done;
          else if (d.run) begin nst = S_RUN; m_byp = (m_pc == int'(bp_addr)); end
        end
      endcase
      if (iss) begin
        e.instr = m_mem[m_pc % DEPTH];
        if (m_cnt < 65535) m_cnt++;
      end
      // Toy core: held at pc 0 while in reset, advances (or jumps) per instruction.
      if (m_st == S_IDLE || m_st == S_LOAD || m_st == S_BOOT) m_pc = 0;
      else if (iss) begin
        if (jumps && $urandom_range(0, 7) == 0) m_pc = $urandom_range(0, m_len + 1);
        else if (m_pc < 255) m_pc++;
      end
      m_st = nst;
    end
    e.st   = 3'(m_st);
    e.crst = !(m_st == S_RUN || m_st == S_PAUSE);
    e.lr   = (m_st == S_LOAD);
    e.done = m_done; e.bp = m_bp; e.cnt = 16'(m_cnt);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: registered outputs are compared just after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("core_instr", 32'(core_instr), 32'(e.instr));
        chk("core_rst",   32'(core_rst),   32'(e.crst));
        chk("state",      32'(state),      32'(e.st));
        chk("done",       32'(done),       32'(e.done));
        chk("bp_hit",     32'(bp_hit),     32'(e.bp));
        chk("exec_count", 32'(exec_count), 32'(e.cnt));
        chk("load_ready", 32'(load_ready), 32'(e.lr));
      end
    end
  end

  task automatic load_prog(input int n, input bit use_last);
    in_t d;
    int  i = 0, guard = 0;
    d = '0; d.load_start = 1; cyc(d);
    while (i < n && guard < 1000) begin
      d = '0;
      d.load_valid = ($urandom_range(0, 3) != 0);
      d.load_data  = 6'($urandom);
      d.load_last  = use_last && (i == n - 1);
      cyc(d);
      if (d.load_valid) i++;
      guard++;
    end
  endtask

  task automatic wait_st(input int tgt, input int lim);
    int k = 0;
    while (m_st != tgt && k < lim) begin cyc('0); k++; end
    if (m_st != tgt) begin
      n_chk++; n_fail++;
      $display("FAIL wait_state: state %0d not reached within %0d cycles", tgt, lim);
    end
  endtask

  initial begin
    in_t d;
    int  k;
    bp_en = 0; bp_addr = 8'd0;
    d = '0; d.rst = 1; cyc(d); cyc(d);
    chk("reset_state", 32'(state), 32'(S_IDLE));
    chk("reset_core_rst", 32'(core_rst), 32'd1);
    d = '0; d.run = 1; cyc(d); cyc('0);
    chk("run_empty_ignored", 32'(state), 32'(S_IDLE));

    // Full-depth load without load_last, then a stray extra word in IDLE.
    load_prog(DEPTH, 0);
    chk("autoexit_state", 32'(state), 32'(S_IDLE));
    d = '0; d.load_valid = 1; d.load_data = 6'h3F; cyc(d); cyc('0);

    // Four-word program, run to completion.
    load_prog(4, 1);
    chk("load4_state", 32'(state), 32'(S_IDLE));
    d = '0; d.run = 1; cyc(d);
    wait_st(S_PAUSE, 20);
    chk("run_done", 32'(done), 32'd1);
    chk("run_count", 32'(exec_count), 32'd4);

    // Breakpoint at pc 2, then resume through it.
    bp_en = 1; bp_addr = 8'd2;
    d = '0; d.restart = 1; cyc(d);
    wait_st(S_PAUSE, 20);
    chk("bp_hit", 32'(bp_hit), 32'd1);
    chk("bp_count", 32'(exec_count), 32'd2);
    d = '0; d.run = 1; cyc(d);
    wait_st(S_PAUSE, 20);
    chk("bp_resume_count", 32'(exec_count), 32'd4);
    chk("bp_resume_done", 32'(done), 32'd1);
    bp_en = 0;

    // Halt at pc 1, three single steps, then halt+run together.
    d = '0; d.restart = 1; cyc(d);
    k = 0;
    while (!(m_st == S_RUN && m_pc == 1) && k < 20) begin cyc('0); k++; end
    d = '0; d.halt = 1; cyc(d);
    chk("halt_state", 32'(state), 32'(S_PAUSE));
    for (int i = 0; i < 3; i++) begin d = '0; d.step = 1; cyc(d); cyc('0); end
    chk("step_count", 32'(exec_count), 32'd4);
    chk("step_state", 32'(state), 32'(S_PAUSE));
    d = '0; d.halt = 1; d.run = 1; cyc(d); cyc('0);
    chk("halt_run_state", 32'(state), 32'(S_PAUSE));

    // Reset in the middle of RUN.
    d = '0; d.restart = 1; cyc(d); cyc('0); cyc('0);
    chk("pre_rst_state", 32'(state), 32'(S_RUN));
    d = '0; d.rst = 1; cyc(d);
    chk("midrun_rst_state", 32'(state), 32'(S_IDLE));
    chk("midrun_rst_instr", 32'(core_instr), 32'd0);
    chk("midrun_rst_count", 32'(exec_count), 32'd0);
    d = '0; d.run = 1; cyc(d); cyc('0);
    chk("len_cleared", 32'(state), 32'(S_IDLE));

    // Randomised control traffic with a jumping core pc.
    load_prog($urandom_range(1, DEPTH), 1);
    jumps = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 100 == 0) begin bp_en = $urandom_range(0, 1); bp_addr = 8'($urandom_range(0, DEPTH)); end
      d = '0;
      d.rst        = ($urandom_range(0, 499) == 0);
      d.load_start = ($urandom_range(0, 39) == 0);
      d.load_valid = $urandom_range(0, 1);
      d.load_last  = ($urandom_range(0, 5) == 0);
      d.load_data  = 6'($urandom);
      d.run        = ($urandom_range(0, 7) == 0);
      d.halt       = ($urandom_range(0, 24) == 0);
      d.step       = ($urandom_range(0, 9) == 0);
      d.restart    = ($urandom_range(0, 59) == 0);
      cyc(d);
    end
    cyc('0);
    @(posedge clk); #2;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
